uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

Byte-level UART receive framer, directly downstream of the 16x-oversampling line sampler. It consumes the sampler's re-timed serial level, detects start bits, and samples each bit at mid-period on its own oversample tick. It checks the stop bit and presents 8N1 bytes through a single-entry valid/ready holding register, with framing and overrun flags for the command-parsing logic above it.

## Interface
- CLK_HZ, 65_000_000, system clock frequency in Hz
- SAMP_PER_BIT, 16, oversample ticks per bit; even, ≥4
- BAUD_RATE, 9600, line rate in bits/s
- DATA_BITS, 8, payload bits per frame, LSB first
- clk_in  input  1  system clock; one clock domain
- rst_in  input  1  reset, synchronous, active-high
- sig_in  input  1  sampled serial line from the sampler; idle high
- ready_in  input  1  consumer accepts data_out this cycle
- data_out  output  DATA_BITS  received byte
- valid_out  output  1  data_out holds an unconsumed byte
- framing_err_out  output  1  one-cycle pulse: stop bit sampled low
- overrun_out  output  1  one-cycle pulse: byte completed while the previous byte was unconsumed

## Operation
- Tick: DIV = CLK_HZ/(SAMP_PER_BIT*BAUD_RATE), integer division; defaults give 423. A 16-bit down-counter reloads to DIV-1 and asserts tick for one cycle at 0. It is free-running and not phase-locked to the sampler. DIV must be in 1..65536.
- Sample counter s: $clog2(SAMP_PER_BIT) bits. Bit index b: $clog2(DATA_BITS+1) bits. Shift register sr: DATA_BITS bits. All registers update only on tick, except the output handshake.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a tick with sig_in=0, set s←0 and go to START.
- START: on each tick s←s+1. On the tick where s==SAMP_PER_BIT/2-1 (mid start bit), sample sig_in:
  - 0: s←0, b←0, go to DATA.
  - 1: glitch; return to IDLE with no flag.
- DATA: each tick s←s+1. At s==SAMP_PER_BIT-1: sr←{sig_in, sr[DATA_BITS-1:1]}, s←0, b←b+1. After the DATA_BITS-th bit, go to STOP.
- STOP: at s==SAMP_PER_BIT-1, sample sig_in:
  - 1: deliver sr, go to IDLE.
  - 0: pulse framing_err_out, discard sr, go to WAIT_IDLE.
- WAIT_IDLE: on a tick with sig_in=1, go to IDLE. A held-low break line produces exactly one framing error.
- Delivery: data_out←sr, valid_out←1.
  - If valid_out was already 1 and ready_in=0 that cycle: overwrite data_out and pulse overrun_out.
  - If valid_out=1 and ready_in=1 in the delivery cycle: the old byte is consumed, the new byte is loaded, valid_out stays 1, no overrun.
- Handshake: when valid_out=1 and ready_in=1 with no delivery, valid_out←0 next cycle. data_out is held stable while valid_out=1 until it is accepted or overwritten. ready_in is ignored while valid_out=0.

## Timing
- Reset values:
  - State IDLE; tick counter DIV-1; s, b, sr = 0.
  - data_out=0, valid_out=0, framing_err_out=0, overrun_out=0.
- Reset mid-frame abandons the frame: no flag, no delivery.
- Bit period = SAMP_PER_BIT*DIV cycles (6768 at defaults).
- Sample point = start detection + (SAMP_PER_BIT/2 + k*SAMP_PER_BIT) ticks. Phase uncertainty is ≤1 tick of detection plus the sampler's ≤1-tick lag.
- valid_out and framing_err_out rise in the cycle after the stop-sample tick. Nominal latency from the start edge is 9.5 bit periods + ≤2 ticks.
- A new start bit is detectable from the first tick after returning to IDLE, so back-to-back frames are supported.

## Structure
- A shared uart_pkg holds:
  - The rx_state_t enum.
  - Default CLK_HZ/SAMP_PER_BIT/BAUD_RATE, so the sampler and framer agree.
  - A function computing DIV.
- Sub-module uart_tick_gen (CLK_HZ, SAMP_PER_BIT, BAUD_RATE; clk_in, rst_in → tick_out) is the natural split. The sampler can later reuse it.

## Test plan
Bench parameters: CLK_HZ=160, BAUD_RATE=1, SAMP_PER_BIT=16, so DIV=10 and a bit is 160 cycles.
- Send frame 0xA5 (0,1,0,1,0,0,1,0,1,1), ready_in=1 → one valid_out pulse with data_out=0xA5; no flags.
- Low glitch of 50 cycles on an idle line → no valid_out, no framing_err_out, FSM back in IDLE.
- Frame 0x3C with stop bit low, line held low for 3 bit periods → one framing_err_out pulse, no valid_out. Then after the line returns high, frame 0x11 → data_out=0x11.
- ready_in=0, frames 0x01 then 0x02 → overrun_out pulses once, data_out=0x02, valid_out=1. Then ready_in=1 for one cycle → valid_out=0.
- rst_in for one cycle at bit 4 of frame 0xFF → all outputs at reset values. The next clean frame 0x5A is received correctly.
- Two back-to-back frames 0x00, 0xFF with zero idle gap → both delivered in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding, default line parameters
// and the oversample tick divider, so the sampler and framer agree.
package uart_pkg;

    localparam int unsigned CLK_HZ_DEF       = 65_000_000;
    localparam int unsigned SAMP_PER_BIT_DEF = 16;
    localparam int unsigned BAUD_RATE_DEF    = 9600;
    localparam int unsigned DATA_BITS_DEF    = 8;
    localparam int unsigned TICK_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // System clocks per oversample tick; valid range is 1..65536.
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned samp_per_bit,
                                             input int unsigned baud_rate);
        return clk_hz / (samp_per_bit * baud_rate);
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Serial input and byte-side valid/ready bus of the UART receive framer.
interface uart_rx_framer_if #(
    parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
);
    logic                 sig_in;
    logic                 ready_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 framing_err_out;
    logic                 overrun_out;

    modport master (
        input  sig_in,
        input  ready_in,
        output data_out,
        output valid_out,
        output framing_err_out,
        output overrun_out
    );

    modport slave (
        output sig_in,
        output ready_in,
        input  data_out,
        input  valid_out,
        input  framing_err_out,
        input  overrun_out
    );
endinterface

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV system clocks.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
    parameter int unsigned SAMP_PER_BIT = SAMP_PER_BIT_DEF,
    parameter int unsigned BAUD_RATE    = BAUD_RATE_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int unsigned DIV = uart_div(CLK_HZ, SAMP_PER_BIT, BAUD_RATE);
    localparam logic [TICK_CNT_W-1:0] RELOAD = TICK_CNT_W'(DIV - 1);

    logic [TICK_CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt      <= RELOAD;
            tick_out <= 1'b0;
        end else begin
            tick_out <= (cnt == '0);
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - TICK_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: start detection, mid-bit sampling on oversample
// ticks, stop-bit check and a single-entry valid/ready holding register.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
    parameter int unsigned SAMP_PER_BIT = SAMP_PER_BIT_DEF,
    parameter int unsigned BAUD_RATE    = BAUD_RATE_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    uart_rx_framer_if.master  bus
);

    localparam int unsigned SW = $clog2(SAMP_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic                 tick;
    logic                 sig;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [SW-1:0]        s;
    logic [BW-1:0]        b;
    logic [DATA_BITS-1:0] sr;

    logic s_mid;
    logic s_last;
    logic b_last;
    logic s_clr;
    logic s_inc;
    logic b_clr;
    logic b_inc;
    logic shift_en;
    logic deliver_c;
    logic frame_err_c;

    uart_tick_gen #(
        .CLK_HZ       (CLK_HZ),
        .SAMP_PER_BIT (SAMP_PER_BIT),
        .BAUD_RATE    (BAUD_RATE)
    ) u_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_out (tick)
    );

    assign sig    = bus.sig_in;
    assign s_mid  = (s == SW'(SAMP_PER_BIT / 2 - 1));
    assign s_last = (s == SW'(SAMP_PER_BIT - 1));
    assign b_last = (b == BW'(DATA_BITS - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                IDLE:      if (!sig) state_next = START;
                START:     if (s_mid) state_next = sig ? IDLE : DATA;
                DATA:      if (s_last && b_last) state_next = STOP;
                STOP:      if (s_last) state_next = sig ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (sig) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Datapath strobes; everything except the handshake advances only on tick.
    always_comb begin
        s_clr       = 1'b0;
        s_inc       = 1'b0;
        b_clr       = 1'b0;
        b_inc       = 1'b0;
        shift_en    = 1'b0;
        deliver_c   = 1'b0;
        frame_err_c = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!sig) s_clr = 1'b1;
                end
                START: begin
                    if (s_mid) begin
                        s_clr = 1'b1;
                        b_clr = 1'b1;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (s_last) begin
                        shift_en = 1'b1;
                        s_clr    = 1'b1;
                        b_inc    = 1'b1;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (s_last) begin
                        deliver_c   = sig;
                        frame_err_c = !sig;
                        s_clr       = 1'b1;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s  <= '0;
            b  <= '0;
            sr <= '0;
        end else begin
            if (s_clr) begin
                s <= '0;
            end else if (s_inc) begin
                s <= s + SW'(1);
            end
            if (b_clr) begin
                b <= '0;
            end else if (b_inc) begin
                b <= b + BW'(1);
            end
            if (shift_en) begin
                sr <= {sig, sr[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register: a delivery wins over a same-cycle accept.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.data_out        <= '0;
            bus.valid_out       <= 1'b0;
            bus.framing_err_out <= 1'b0;
            bus.overrun_out     <= 1'b0;
        end else begin
            bus.framing_err_out <= frame_err_c;
            bus.overrun_out     <= deliver_c && bus.valid_out && !bus.ready_in;
            if (deliver_c) begin
                bus.data_out  <= sr;
                bus.valid_out <= 1'b1;
            end else if (bus.valid_out && bus.ready_in) begin
                bus.valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer at DIV=10 (160 clocks per bit).
module tb_uart_rx_framer;
    import uart_pkg::*;

    localparam int unsigned BIT_CYC = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_framer_if #(.DATA_BITS(8)) bus ();

    uart_rx_framer #(
        .CLK_HZ       (160),
        .SAMP_PER_BIT (16),
        .BAUD_RATE    (1),
        .DATA_BITS    (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         valid_rises = 0;
    int         fe_pulses = 0;
    int         ov_pulses = 0;
    logic       valid_d = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: event counters and scoreboard pops on accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out && !valid_d) valid_rises <= valid_rises + 1;
            if (bus.framing_err_out) fe_pulses <= fe_pulses + 1;
            if (bus.overrun_out) ov_pulses <= ov_pulses + 1;
            if (bus.valid_out && bus.ready_in) begin
                check("sb_depth", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
        valid_d <= bus.valid_out;
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bits(input logic v, input int n_cycles);
        bus.sig_in = v;
        wait_clk(n_cycles);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bits(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CYC);
        drive_bits(stop_v, BIT_CYC);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(bus.data_out), 32'd0);
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_ferr"}, 32'(bus.framing_err_out), 32'd0);
        check({tag, "_ovr"}, 32'(bus.overrun_out), 32'd0);
    endtask

    int v0, f0, o0;

    task automatic snap();
        v0 = valid_rises;
        f0 = fe_pulses;
        o0 = ov_pulses;
    endtask

    initial begin
        bus.sig_in   = 1'b1;
        bus.ready_in = 1'b0;
        rst          = 1'b1;
        wait_clk(3);
        check_reset_outputs("rst");
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        wait_clk(20);

        // Clean frame with consumer always ready.
        bus.ready_in = 1'b1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clk(2 * BIT_CYC);
        check("a5_valid", 32'(valid_rises - v0), 32'd1);
        check("a5_ferr", 32'(fe_pulses - f0), 32'd0);
        check("a5_ovr", 32'(ov_pulses - o0), 32'd0);
        check("a5_sb", 32'(exp_q.size()), 32'd0);

        // Short low glitch on idle line.
        snap();
        drive_bits(1'b0, 50);
        drive_bits(1'b1, 2 * BIT_CYC);
        check("gl_valid", 32'(valid_rises - v0), 32'd0);
        check("gl_ferr", 32'(fe_pulses - f0), 32'd0);
        check("gl_state", 32'(dut.state), 32'(IDLE));

        // Stop bit low followed by a held break.
        snap();
        send_frame(8'h3C, 1'b0);
        drive_bits(1'b0, 2 * BIT_CYC);
        drive_bits(1'b1, 2 * BIT_CYC);
        check("br_ferr", 32'(fe_pulses - f0), 32'd1);
        check("br_valid", 32'(valid_rises - v0), 32'd0);
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_clk(2 * BIT_CYC);
        check("p11_valid", 32'(valid_rises - v0), 32'd1);
        check("p11_sb", 32'(exp_q.size()), 32'd0);

        // Overrun: consumer stalled across two frames; the first byte is lost.
        bus.ready_in = 1'b0;
        snap();
        send_frame(8'h01, 1'b1);
        wait_clk(BIT_CYC);
        exp_q.push_back(8'h02);
        send_frame(8'h02, 1'b1);
        wait_clk(BIT_CYC);
        check("ov_pulse", 32'(ov_pulses - o0), 32'd1);
        check("ov_data", 32'(bus.data_out), 32'h02);
        check("ov_valid", 32'(bus.valid_out), 32'd1);
        bus.ready_in = 1'b1;
        wait_clk(1);
        bus.ready_in = 1'b0;
        check("ov_drain", 32'(bus.valid_out), 32'd0);
        check("ov_sb", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame at bit 4 of 0xFF.
        bus.ready_in = 1'b1;
        snap();
        drive_bits(1'b0, BIT_CYC);
        drive_bits(1'b1, 4 * BIT_CYC + BIT_CYC / 2);
        rst = 1'b1;
        wait_clk(1);
        check_reset_outputs("mid_rst");
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        drive_bits(1'b1, 6 * BIT_CYC);
        check("mid_rst_valid", 32'(valid_rises - v0), 32'd0);
        check("mid_rst_ferr", 32'(fe_pulses - f0), 32'd0);
        snap();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clk(2 * BIT_CYC);
        check("p5a_valid", 32'(valid_rises - v0), 32'd1);
        check("p5a_sb", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        snap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(2 * BIT_CYC);
        check("b2b_valid", 32'(valid_rises - v0), 32'd2);
        check("b2b_ferr", 32'(fe_pulses - f0), 32'd0);
        check("b2b_sb", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
